// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    // Controller state: normal flow, waiting on data memory, sticky timeout
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
// Performance counter outputs exist only when PIPE_HAZARD_PERF_EN is defined.
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_PERF_EN
#(
    parameter int unsigned PERF_W = 32
)
`endif
;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] ifid_rs1;
    logic [REG_ADDR_W-1:0] ifid_rs2;
    logic                  ifid_use_rs1;
    logic                  ifid_use_rs2;
    logic                  idex_mem_read;
    logic [REG_ADDR_W-1:0] idex_rd;
    logic                  ex_redirect;
    logic                  exmem_mem_read;
    logic                  exmem_mem_write;
    logic                  dmem_ready;
    logic                  dmem_valid;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  idex_en;
    logic                  exmem_en;
    logic                  memwb_en;
    logic                  ifid_flush;
    logic                  idex_flush;
    logic                  memwb_flush;
    logic                  pc_redirect;
    logic                  mem_fault;
`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0]     perf_lu_cnt;
    logic [PERF_W-1:0]     perf_mem_cnt;
    logic [PERF_W-1:0]     perf_flush_cnt;
`endif

    // Datapath side: supplies decoded fields, consumes pipeline controls
    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
        output idex_mem_read, idex_rd, ex_redirect,
        output exmem_mem_read, exmem_mem_write, dmem_ready,
`ifdef PIPE_HAZARD_PERF_EN
        input  perf_lu_cnt, perf_mem_cnt, perf_flush_cnt,
`endif
        input  dmem_valid, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, memwb_flush, pc_redirect, mem_fault
    );

    // Controller side
    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
        input  idex_mem_read, idex_rd, ex_redirect,
        input  exmem_mem_read, exmem_mem_write, dmem_ready,
`ifdef PIPE_HAZARD_PERF_EN
        output perf_lu_cnt, perf_mem_cnt, perf_flush_cnt,
`endif
        output dmem_valid, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, memwb_flush, pc_redirect, mem_fault
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination a reader in ID needs.
// Purely combinational so it can be reused for forwarding-match checks.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic                  use_rs1_i,
    input  logic                  use_rs2_i,
    input  logic                  mem_read_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    output logic                  lu_o
);

    logic hit_rs1;
    logic hit_rs2;

    // x0 is never a real dependency
    assign hit_rs1 = use_rs1_i & (rs1_i == rd_i);
    assign hit_rs2 = use_rs2_i & (rs2_i == rd_i);
    assign lu_o    = mem_read_i & (rd_i != REG_ZERO) & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline.
// Optional feature macro: PIPE_HAZARD_PERF_EN (saturating performance counters).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
`ifdef PIPE_HAZARD_PERF_EN
    parameter int unsigned PERF_W      = 32,
`endif
    parameter int unsigned TO_W        = 8
)
(
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    ctrl_state_e     state_q, state_d;
    logic            pend_redir_q, pend_redir_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mreq;
    logic stall_m;
    logic redir;
    logic lu;
    logic active;

    hazard_detect u_hazard_detect (
        .rs1_i      (hz.ifid_rs1),
        .rs2_i      (hz.ifid_rs2),
        .use_rs1_i  (hz.ifid_use_rs1),
        .use_rs2_i  (hz.ifid_use_rs2),
        .mem_read_i (hz.idex_mem_read),
        .rd_i       (hz.idex_rd),
        .lu_o       (lu)
    );

    assign active  = (state_q != FAULT);
    assign mreq    = hz.exmem_mem_read | hz.exmem_mem_write;
    assign stall_m = active & mreq & ~hz.dmem_ready;
    assign redir   = hz.ex_redirect | pend_redir_q;

    // State, pending-redirect and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pend_redir_q <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            pend_redir_q <= pend_redir_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    // Next state and pipeline controls, priority FAULT > mem stall > redirect > load-use
    always_comb begin
        state_d        = state_q;
        pend_redir_d   = pend_redir_q;
        wait_cnt_d     = wait_cnt_q;
        hz.dmem_valid  = mreq;
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.idex_en     = 1'b1;
        hz.exmem_en    = 1'b1;
        hz.memwb_en    = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.memwb_flush = 1'b0;
        hz.pc_redirect = 1'b0;
        hz.mem_fault   = 1'b0;

        case (state_q)
            FAULT: begin
                hz.dmem_valid = 1'b0;
                hz.pc_en      = 1'b0;
                hz.ifid_en    = 1'b0;
                hz.idex_en    = 1'b0;
                hz.exmem_en   = 1'b0;
                hz.memwb_en   = 1'b0;
                hz.mem_fault  = 1'b1;
            end
            default: begin
                if (stall_m) begin
                    // Freeze up to EX/MEM, drain a bubble into MEM/WB
                    hz.pc_en       = 1'b0;
                    hz.ifid_en     = 1'b0;
                    hz.idex_en     = 1'b0;
                    hz.exmem_en    = 1'b0;
                    hz.memwb_flush = 1'b1;
                    if (hz.ex_redirect) begin
                        pend_redir_d = 1'b1;
                    end
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = TO_W'(1);
                    end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                        state_d = FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + TO_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (redir) begin
                        hz.pc_redirect = 1'b1;
                        hz.ifid_flush  = 1'b1;
                        hz.idex_flush  = 1'b1;
                        pend_redir_d   = 1'b0;
                    end else if (lu) begin
                        hz.pc_en      = 1'b0;
                        hz.ifid_en    = 1'b0;
                        hz.idex_flush = 1'b1;
                    end
                end
            end
        endcase

        // Hold every stage and bubble the pipe while reset is asserted
        if (!rst_n) begin
            hz.dmem_valid  = 1'b0;
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_en     = 1'b0;
            hz.exmem_en    = 1'b0;
            hz.memwb_en    = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            hz.memwb_flush = 1'b1;
            hz.pc_redirect = 1'b0;
            hz.mem_fault   = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lu_q;
    logic [PERF_W-1:0] perf_mem_q;
    logic [PERF_W-1:0] perf_flush_q;
    logic              lu_evt;
    logic              redir_evt;

    assign lu_evt    = active & ~stall_m & ~redir & lu;
    assign redir_evt = active & ~stall_m & redir;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q    <= '0;
            perf_mem_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            if (lu_evt && (perf_lu_q != '1)) begin
                perf_lu_q <= perf_lu_q + PERF_W'(1);
            end
            if (stall_m && (perf_mem_q != '1)) begin
                perf_mem_q <= perf_mem_q + PERF_W'(1);
            end
            if (redir_evt && (perf_flush_q != '1)) begin
                perf_flush_q <= perf_flush_q + PERF_W'(1);
            end
        end
    end

    assign hz.perf_lu_cnt    = perf_lu_q;
    assign hz.perf_mem_cnt   = perf_mem_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against
// a behavioural model built from stall streaks and a pending-redirect flag.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (TIMEOUT),
        .TO_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: faulted flag, length of the current stall run, pending redirect
    bit m_fault;
    int m_streak;
    bit m_pend;
    int m_lu_cnt, m_mem_cnt, m_flush_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // {valid, pc/ifid/idex/exmem/memwb en, ifid/idex/memwb flush, pc_redirect, mem_fault}
    function automatic logic [10:0] dut_vec();
        return {hif.dmem_valid, hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en,
                hif.memwb_en, hif.ifid_flush, hif.idex_flush, hif.memwb_flush,
                hif.pc_redirect, hif.mem_fault};
    endfunction

    function automatic bit model_lu();
        return hif.idex_mem_read && (hif.idex_rd != 0) &&
               ((hif.ifid_use_rs1 && hif.ifid_rs1 == hif.idex_rd) ||
                (hif.ifid_use_rs2 && hif.ifid_rs2 == hif.idex_rd));
    endfunction

    function automatic logic [10:0] model_expect();
        bit mreq;
        bit stall;
        mreq  = hif.exmem_mem_read | hif.exmem_mem_write;
        stall = mreq & ~hif.dmem_ready;
        if (!rst_n)                    return 11'b0_00000_111_0_0;
        else if (m_fault)              return 11'b0_00000_000_0_1;
        else if (stall)                return 11'b1_00001_001_0_0;
        else if (hif.ex_redirect || m_pend) return {mreq, 10'b11111_110_1_0};
        else if (model_lu())           return {mreq, 10'b00111_010_0_0};
        else                           return {mreq, 10'b11111_000_0_0};
    endfunction

    task automatic model_advance();
        bit stall;
        bit redir;
        stall = (hif.exmem_mem_read | hif.exmem_mem_write) & ~hif.dmem_ready;
        redir = hif.ex_redirect | m_pend;
        if (!rst_n) begin
            m_fault = 0; m_streak = 0; m_pend = 0;
            m_lu_cnt = 0; m_mem_cnt = 0; m_flush_cnt = 0;
        end else if (!m_fault) begin
            if (stall) begin
                m_mem_cnt++;
                m_streak++;
                if (hif.ex_redirect) m_pend = 1;
                if (m_streak > TIMEOUT) m_fault = 1;
            end else begin
                m_streak = 0;
                if (redir) begin
                    m_flush_cnt++;
                    m_pend = 0;
                end else if (model_lu()) begin
                    m_lu_cnt++;
                end
            end
        end
    endtask

    // One clock: compare mid-cycle, advance the model, then open the next drive window
    task automatic cycle(input string tag);
        logic [10:0] got;
        logic [10:0] exp;
        @(negedge clk);
        exp = model_expect();
        got = dut_vec();
        if (rst_n && m_fault) got = got & 11'b11111100001;
        check(tag, 32'(got), 32'(exp));
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hif.ifid_rs1 = '0; hif.ifid_rs2 = '0;
        hif.ifid_use_rs1 = 1'b0; hif.ifid_use_rs2 = 1'b0;
        hif.idex_mem_read = 1'b0; hif.idex_rd = '0;
        hif.ex_redirect = 1'b0;
        hif.exmem_mem_read = 1'b0; hif.exmem_mem_write = 1'b0;
        hif.dmem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle("reset");
        rst_n = 1'b1;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic use1);
        hif.idex_mem_read = 1'b1; hif.idex_rd = rd;
        hif.ifid_rs1 = 5'd5; hif.ifid_use_rs1 = use1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        m_fault = 0; m_streak = 0; m_pend = 0;
        m_lu_cnt = 0; m_mem_cnt = 0; m_flush_cnt = 0;
        #1;
        cycle("reset");
        cycle("reset_hold");
        rst_n = 1'b1;
        cycle("run_idle");

        // Load-use: one bubble then normal flow as the load moves on to MEM
        set_load_use(5'd5, 1'b1);
        cycle("lu_stall");
        idle_inputs(); hif.exmem_mem_read = 1'b1;
        cycle("lu_after");
        // Load-use masked by x0 or by an unused operand
        idle_inputs(); set_load_use(5'd0, 1'b1);
        cycle("lu_x0");
        idle_inputs(); set_load_use(5'd5, 1'b0);
        cycle("lu_nouse");

        // Memory wait of three cycles, then ready
        idle_inputs(); hif.exmem_mem_read = 1'b1; hif.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("mem_wait");
        hif.dmem_ready = 1'b1;
        cycle("mem_ready");
        idle_inputs();
        cycle("mem_back_run");

        // Redirect during a stall is held and applied on the ready cycle
        hif.exmem_mem_write = 1'b1; hif.dmem_ready = 1'b0; hif.ex_redirect = 1'b1;
        cycle("redir_in_stall");
        hif.ex_redirect = 1'b0;
        cycle("redir_stall2");
        hif.dmem_ready = 1'b1;
        cycle("redir_ready");
        idle_inputs();
        cycle("redir_done");

        // Timeout: five stalled cycles then sticky fault until reset
        hif.exmem_mem_read = 1'b1; hif.dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) cycle("to_stall");
        cycle("to_fault");
        hif.dmem_ready = 1'b1;
        cycle("to_fault_sticky");
        check("mem_fault_set", 32'(hif.mem_fault), 32'd1);
        idle_inputs();
        do_reset();
        check("mem_fault_clr", 32'(hif.mem_fault), 32'd0);
        cycle("post_fault_run");

`ifdef PIPE_HAZARD_PERF_EN
        // Two load-use stalls and one redirect
        do_reset();
        set_load_use(5'd5, 1'b1);
        cycle("perf_lu1");
        idle_inputs();
        cycle("perf_gap");
        set_load_use(5'd5, 1'b1);
        cycle("perf_lu2");
        idle_inputs(); hif.ex_redirect = 1'b1;
        cycle("perf_redir");
        idle_inputs();
        check("perf_lu_cnt", hif.perf_lu_cnt, 32'd2);
        check("perf_flush_cnt", hif.perf_flush_cnt, 32'd1);
        check("perf_mem_cnt", hif.perf_mem_cnt, 32'd0);
        do_reset();
`endif

        // Random traffic with occasional reset pulses
        for (int n = 0; n < 3000; n++) begin
            hif.ifid_rs1       = 5'($urandom_range(0, 3));
            hif.ifid_rs2       = 5'($urandom_range(0, 3));
            hif.ifid_use_rs1   = 1'($urandom_range(0, 1));
            hif.ifid_use_rs2   = 1'($urandom_range(0, 1));
            hif.idex_mem_read  = 1'($urandom_range(0, 1));
            hif.idex_rd        = 5'($urandom_range(0, 3));
            hif.ex_redirect    = ($urandom_range(0, 3) == 0);
            hif.exmem_mem_read = ($urandom_range(0, 2) == 0);
            hif.exmem_mem_write = ($urandom_range(0, 3) == 0);
            hif.dmem_ready     = ($urandom_range(0, 9) < 6);
            rst_n              = ($urandom_range(0, 59) != 0);
            cycle("random");
        end
        rst_n = 1'b1;
        idle_inputs();
        cycle("random_end");
`ifdef PIPE_HAZARD_PERF_EN
        check("rnd_perf_lu", hif.perf_lu_cnt, 32'(m_lu_cnt));
        check("rnd_perf_mem", hif.perf_mem_cnt, 32'(m_mem_cnt));
        check("rnd_perf_flush", hif.perf_flush_cnt, 32'(m_flush_cnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the five-stage pipeline.
- Drives the enable and flush (bubble) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves three events: load-use hazards, EX-stage redirects (taken branch/jump), and data-memory wait states signalled by a valid/ready handshake.
- Sits beside the datapath; only consumes decoded fields from the pipeline registers.

Parameters:
- MEM_TIMEOUT, 16: max consecutive MEM_WAIT cycles before fault; range 1..255.
- TO_W, 8: width of the wait counter; must satisfy MEM_TIMEOUT < 2^TO_W.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ifid_rs1  in  5  rs1 field of the instruction in ID.
- ifid_rs2  in  5  rs2 field of the instruction in ID.
- ifid_use_rs1  in  1  ID instruction reads rs1.
- ifid_use_rs2  in  1  ID instruction reads rs2.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle.
- exmem_mem_read  in  1  MEM-stage load.
- exmem_mem_write  in  1  MEM-stage store.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_valid  out  1  access request to data memory.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  load a bubble (all control bits 0).
- pc_redirect  out  1  PC selects the EX target.
- mem_fault  out  1  sticky timeout error.

Behaviour:
- States: RUN, MEM_WAIT, FAULT. Registered state: `pend_redir` (1 bit), `wait_cnt` (TO_W bits).
- Reset, asynchronous: state=RUN, pend_redir=0, wait_cnt=0, mem_fault=0. While rst_n=0, all *_en=0, all *_flush=1 and dmem_valid=0.
- Outputs are combinational from state and inputs; all other state is registered.
- `mreq` = exmem_mem_read | exmem_mem_write. `dmem_valid` = mreq while state≠FAULT; it is held stable until ready is seen.
- `lu` (load-use) = idex_mem_read & (idex_rd≠0) & ((ifid_use_rs1 & rs1==idex_rd) | (ifid_use_rs2 & rs2==idex_rd)).
- `redir` = ex_redirect | pend_redir.
- Priority: FAULT > memory stall > redirect > load-use > run.
- Memory stall, `stall_m` = mreq & ~dmem_ready (in RUN or MEM_WAIT):
  - pc/ifid/idex/exmem_en=0, memwb_en=1, memwb_flush=1; all other flushes 0.
  - If ex_redirect=1 during the stall, set pend_redir (the redirect is not lost).
- Redirect, no stall_m: all en=1, pc_redirect=1, ifid_flush=1, idex_flush=1; pend_redir cleared at the clock edge. The target is held by EX because exmem/idex were frozen.
- Load-use, no stall_m and no redir: pc_en=0, ifid_en=0, idex_flush=1, exmem/memwb_en=1. Lasts exactly one cycle, since the load then advances to MEM.
- Otherwise all en=1, all flush=0.
- Transitions:
  - RUN→MEM_WAIT on stall_m; wait_cnt←1.
  - MEM_WAIT: dmem_ready=1 → RUN, wait_cnt←0; the access completes and the pipeline advances that cycle.
  - MEM_WAIT: else wait_cnt+1; if wait_cnt==MEM_TIMEOUT → FAULT.
  - FAULT: all en=0, dmem_valid=0, mem_fault=1; leaves only via reset.
- A single-cycle access (ready in the same cycle as the request) never enters MEM_WAIT.
- Reset mid-stall discards pend_redir and wait_cnt.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With the macro defined:
  - Extra outputs perf_lu_cnt, perf_mem_cnt, perf_flush_cnt, each [PERF_W-1:0].
  - They count load-use stall cycles, stall_m cycles and redirect events.
  - Each saturates at all-ones and clears on reset.
- Without the macro: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, FAULT};
  - REG_ADDR_W=5 and the zero-register constant.
- One sub-module, hazard_detect: combinational lu computation; reusable for forwarding checks.

Test Plan:
- Load-use: idex_mem_read=1, idex_rd=5, ifid_rs1=5, use_rs1=1, dmem_ready=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1, then normal.
- Load-use masked: same as above with idex_rd=0, or with use_rs1=0 → no stall.
- Memory wait: exmem_mem_read=1, dmem_ready low for 3 cycles → 3 cycles of exmem_en=0 and memwb_flush=1; state returns to RUN on the ready cycle.
- Simultaneous events: ex_redirect=1 during the memory stall, ready arriving 2 cycles later → pc_redirect=1, ifid_flush=1 and idex_flush=1 on the ready cycle only.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low → mem_fault=1 after 5 stalled cycles, all en=0; mem_fault cleared only by rst_n pulse.
- Perf (macro defined): 2 load-use stalls + 1 redirect → perf_lu_cnt=2, perf_flush_cnt=1.
